// File: rtl/rix_axi_pkg.sv
// Shared AXI constants and helpers for the rix memory-side arbiters.
package rix_axi_pkg;

    localparam int unsigned TAG_WIDTH      = 2;
    localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
    localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;

    // Ceiling log2, usable in constant expressions (e.g. arsize from bus width).
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr_i wins.
module rr_arbiter #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            int unsigned cand;
            cand = 32'(ptr_i) + i;
            if (cand >= N) begin
                cand = cand - N;
            end
            for (int unsigned j = 0; j < N; j++) begin
                if (!valid_o && (j == cand) && req_i[j]) begin
                    valid_o  = 1'b1;
                    gnt_o[j] = 1'b1;
                    idx_o    = IDX_W'(j);
                end
            end
        end
    end

endmodule

// File: rtl/axi_read_arbiter.sv
// Shares one AXI4 read port among PORTS requesters: round-robin AR with ID tagging,
// tag-based R routing and a per-port cap on bursts in flight.
module axi_read_arbiter
    import rix_axi_pkg::*;
#(
    parameter int unsigned PORTS           = 3,
    parameter int unsigned ADDR_WIDTH      = 25,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned ID_WIDTH        = 8,
    parameter int unsigned SID_WIDTH       = ID_WIDTH - 2,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                         aclk,
    input  logic                         resetn,
    input  logic [PORTS*SID_WIDTH-1:0]   s_axi_arid,
    input  logic [PORTS*ADDR_WIDTH-1:0]  s_axi_araddr,
    input  logic [PORTS*8-1:0]           s_axi_arlen,
    input  logic [PORTS-1:0]             s_axi_arvalid,
    output logic [PORTS-1:0]             s_axi_arready,
    output logic [SID_WIDTH-1:0]         s_axi_rid,
    output logic [DATA_WIDTH-1:0]        s_axi_rdata,
    output logic [1:0]                   s_axi_rresp,
    output logic                         s_axi_rlast,
    output logic [PORTS-1:0]             s_axi_rvalid,
    input  logic [PORTS-1:0]             s_axi_rready,
    output logic [ID_WIDTH-1:0]          m_axi_arid,
    output logic [ADDR_WIDTH-1:0]        m_axi_araddr,
    output logic [7:0]                   m_axi_arlen,
    output logic [2:0]                   m_axi_arsize,
    output logic [1:0]                   m_axi_arburst,
    output logic                         m_axi_arlock,
    output logic [3:0]                   m_axi_arcache,
    output logic [2:0]                   m_axi_arprot,
    output logic                         m_axi_arvalid,
    input  logic                         m_axi_arready,
    input  logic [ID_WIDTH-1:0]          m_axi_rid,
    input  logic [DATA_WIDTH-1:0]        m_axi_rdata,
    input  logic [1:0]                   m_axi_rresp,
    input  logic                         m_axi_rlast,
    input  logic                         m_axi_rvalid,
    output logic                         m_axi_rready,
    output logic                         idle,
    output logic                         err_bad_tag
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned ARSIZE = clog2(DATA_WIDTH / 8);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ISSUE = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [TAG_WIDTH-1:0]  ptr_q, ptr_d;
    logic [TAG_WIDTH-1:0]  gidx_q, gidx_d;
    logic [SID_WIDTH-1:0]  arid_q, arid_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [7:0]            arlen_q, arlen_d;
    logic [CNT_W-1:0]      outst_q [PORTS];
    logic [CNT_W-1:0]      outst_d [PORTS];
    logic                  err_q, err_d;

    logic [PORTS-1:0]      elig;
    logic [PORTS-1:0]      arb_gnt;
    logic [TAG_WIDTH-1:0]  arb_idx;
    logic                  arb_valid;
    logic [SID_WIDTH-1:0]  sel_arid;
    logic [ADDR_WIDTH-1:0] sel_araddr;
    logic [7:0]            sel_arlen;
    logic [PORTS-1:0]      inc;
    logic [PORTS-1:0]      dec;
    logic [TAG_WIDTH-1:0]  rtag;
    logic                  tag_ok;
    logic                  r_last_fire;
    logic                  all_zero;

    always_comb begin
        for (int unsigned p = 0; p < PORTS; p++) begin
            elig[p] = s_axi_arvalid[p] && (outst_q[p] < CNT_W'(MAX_OUTSTANDING));
        end
    end

    rr_arbiter #(
        .N     (PORTS),
        .IDX_W (TAG_WIDTH)
    ) u_rr_arbiter (
        .req_i   (elig),
        .ptr_i   (ptr_q),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    // Request field mux driven by the one-hot grant.
    always_comb begin
        sel_arid   = '0;
        sel_araddr = '0;
        sel_arlen  = '0;
        for (int unsigned p = 0; p < PORTS; p++) begin
            if (arb_gnt[p]) begin
                sel_arid   = s_axi_arid[p*SID_WIDTH +: SID_WIDTH];
                sel_araddr = s_axi_araddr[p*ADDR_WIDTH +: ADDR_WIDTH];
                sel_arlen  = s_axi_arlen[p*8 +: 8];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        gidx_d        = gidx_q;
        arid_d        = arid_q;
        araddr_d      = araddr_q;
        arlen_d       = arlen_q;
        s_axi_arready = '0;
        inc           = '0;
        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    s_axi_arready = arb_gnt;
                    gidx_d        = arb_idx;
                    arid_d        = sel_arid;
                    araddr_d      = sel_araddr;
                    arlen_d       = sel_arlen;
                    state_d       = ST_ISSUE;
                    ptr_d         = (arb_idx == TAG_WIDTH'(PORTS - 1)) ? '0
                                  : arb_idx + TAG_WIDTH'(1);
                end
            end
            ST_ISSUE: begin
                if (m_axi_arready) begin
                    for (int unsigned p = 0; p < PORTS; p++) begin
                        inc[p] = (gidx_q == TAG_WIDTH'(p));
                    end
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // R routing by the tag carried in the top ID bits; unknown tags are sunk.
    assign rtag = m_axi_rid[ID_WIDTH-1 -: TAG_WIDTH];

    always_comb begin
        s_axi_rvalid = '0;
        m_axi_rready = 1'b1;
        tag_ok       = 1'b0;
        for (int unsigned p = 0; p < PORTS; p++) begin
            if (rtag == TAG_WIDTH'(p)) begin
                tag_ok          = 1'b1;
                s_axi_rvalid[p] = m_axi_rvalid;
                m_axi_rready    = s_axi_rready[p];
            end
        end
    end

    assign r_last_fire = m_axi_rvalid && m_axi_rready && m_axi_rlast;

    always_comb begin
        err_d    = err_q | (m_axi_rvalid & ~tag_ok);
        dec      = '0;
        all_zero = 1'b1;
        for (int unsigned p = 0; p < PORTS; p++) begin
            dec[p]     = r_last_fire && tag_ok && (rtag == TAG_WIDTH'(p));
            outst_d[p] = outst_q[p];
            if (outst_q[p] != '0) begin
                all_zero = 1'b0;
            end
            if (dec[p] && (outst_q[p] == '0)) begin
                err_d = 1'b1;
            end
            if (inc[p] && !(dec[p] && (outst_q[p] != '0))) begin
                outst_d[p] = outst_q[p] + CNT_W'(1);
            end else if (!inc[p] && dec[p] && (outst_q[p] != '0)) begin
                outst_d[p] = outst_q[p] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            gidx_q   <= '0;
            arid_q   <= '0;
            araddr_q <= '0;
            arlen_q  <= '0;
            err_q    <= 1'b0;
            for (int unsigned p = 0; p < PORTS; p++) begin
                outst_q[p] <= '0;
            end
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gidx_q   <= gidx_d;
            arid_q   <= arid_d;
            araddr_q <= araddr_d;
            arlen_q  <= arlen_d;
            err_q    <= err_d;
            for (int unsigned p = 0; p < PORTS; p++) begin
                outst_q[p] <= outst_d[p];
            end
        end
    end

    assign m_axi_arvalid = (state_q == ST_ISSUE);
    assign m_axi_arid    = {gidx_q, arid_q};
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arlen   = arlen_q;
    assign m_axi_arsize  = 3'(ARSIZE);
    assign m_axi_arburst = AXI_BURST_INCR;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = 4'd0;
    assign m_axi_arprot  = 3'd0;

    assign s_axi_rid   = m_axi_rid[SID_WIDTH-1:0];
    assign s_axi_rdata = m_axi_rdata;
    assign s_axi_rresp = m_axi_rresp;
    assign s_axi_rlast = m_axi_rlast;

    assign idle        = (state_q == ST_IDLE) && all_zero && (s_axi_arvalid == '0);
    assign err_bad_tag = err_q;

endmodule

// File: doc/axi_read_arbiter.md
Name: axi_read_arbiter

Overview:
- Shares the single AXI4 read port of the external memory (the axi_ram / DDR side) between up to 4 internal read requesters: texture fetch, framebuffer stream-out, depth/stencil readback and command DMA.
- Arbitrates AR bursts round-robin and tags each burst ID with the requester index.
- Routes R beats back to the owning requester by that tag.
- Limits outstanding bursts per requester so one stalled consumer cannot hold the memory.

Parameters:
- PORTS, 3, number of requesters (1..4).
- ADDR_WIDTH, 25, byte address width.
- DATA_WIDTH, 32, R data width. Power of two, >= 8.
- ID_WIDTH, 8, master-side ID width.
- SID_WIDTH, ID_WIDTH-2, requester-side ID width. The top 2 master ID bits carry the port tag.
- MAX_OUTSTANDING, 4, maximum bursts in flight per port (1..15).

Ports:
- aclk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- s_axi_arid  in  PORTS*SID_WIDTH  packed per-port AR ID. Port p occupies slice p.
- s_axi_araddr  in  PORTS*ADDR_WIDTH  packed AR address.
- s_axi_arlen  in  PORTS*8  packed burst length-1.
- s_axi_arvalid  in  PORTS  per-port AR valid.
- s_axi_arready  out  PORTS  per-port AR ready.
- s_axi_rid  out  SID_WIDTH  R ID with tag stripped, broadcast to all ports.
- s_axi_rdata  out  DATA_WIDTH  broadcast.
- s_axi_rresp  out  2  broadcast.
- s_axi_rlast  out  1  broadcast.
- s_axi_rvalid  out  PORTS  per-port R valid.
- s_axi_rready  in  PORTS  per-port R ready.
- m_axi_arid  out  ID_WIDTH  {tag[1:0], sid}.
- m_axi_araddr  out  ADDR_WIDTH.
- m_axi_arlen  out  8.
- m_axi_arsize  out  3  constant log2(DATA_WIDTH/8).
- m_axi_arburst  out  2  constant 2'b01 (INCR).
- m_axi_arlock, m_axi_arcache, m_axi_arprot  out  1/4/3  constant 0.
- m_axi_arvalid  out  1.
- m_axi_arready  in  1.
- m_axi_rid  in  ID_WIDTH.
- m_axi_rdata  in  DATA_WIDTH.
- m_axi_rresp  in  2.
- m_axi_rlast  in  1.
- m_axi_rvalid  in  1.
- m_axi_rready  out  1.
- idle  out  1  high when no AR is pending and all outstanding counters are 0.
- err_bad_tag  out  1  sticky; set when an R beat arrives with tag >= PORTS.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE, round-robin pointer = 0, all outstanding counters = 0.
  - m_axi_arvalid = 0, s_axi_arready = 0, err_bad_tag = 0, idle = 1.
  - Reset mid-burst abandons in-flight bursts. The memory must be reset together with this block.
- Eligibility: port p is eligible when s_axi_arvalid[p] is high and outst[p] < MAX_OUTSTANDING.
- FSM IDLE:
  - If any port is eligible, pick the first eligible port starting at ptr and wrapping modulo PORTS.
  - In the same cycle: s_axi_arready[g] = 1 (combinational, one-hot). Latch {g, arid, araddr, arlen} into the AR output register.
  - Go to ISSUE. ptr <= (g+1) mod PORTS.
- FSM ISSUE:
  - m_axi_arvalid = 1. Registered fields hold stable.
  - When m_axi_arready is high: outst[g]++, return to IDLE. m_axi_arvalid drops next cycle.
- Timing:
  - AR latency from requester handshake to m_axi_arvalid is 1 cycle.
  - Best-case throughput is one burst per 2 cycles.
  - No s_axi_arready is asserted while in ISSUE.
- R routing (combinational, zero latency):
  - tag = m_axi_rid[ID_WIDTH-1 -: 2].
  - s_axi_rvalid[tag] = m_axi_rvalid. All other bits are 0.
  - m_axi_rready = s_axi_rready[tag].
  - s_axi_rid = m_axi_rid[SID_WIDTH-1:0]. Data, resp and last pass straight through.
- Bad tag (tag >= PORTS): m_axi_rready = 1 (beat is dropped), no s_axi_rvalid is raised, err_bad_tag is set until reset.
- Outstanding decrement: outst[tag]-- on an R handshake with m_axi_rlast = 1.
  - Same-cycle increment and decrement on the same port leave it unchanged.
  - A decrement at 0 is a protocol error: the counter holds at 0 and err_bad_tag is set.
- Starvation bound: a continuously eligible port is granted within PORTS grants.
- idle = (state == IDLE) && all outst == 0 && no s_axi_arvalid.

Decomposition:
- Shared package rix_axi_pkg:
  - AXI_BURST_INCR, AXI_RESP_OKAY.
  - TAG_WIDTH = 2.
  - function clog2 for arsize.
- One sub-module, rr_arbiter:
  - Inputs: request vector, pointer.
  - Outputs: one-hot grant plus index.
  - Combinational; reusable by a future write arbiter.
- Counters, FSM and routing live in axi_read_arbiter.

Test Plan:
- Single request: port1 issues arid=5, araddr=0x1000, arlen=3, m_axi_arready tied 1. Expect:
  - m_axi_arvalid one cycle after the s handshake, m_axi_arid=0x45.
  - 4 R beats delivered only on s_axi_rvalid[1], s_axi_rid=5.
  - idle returns to 1 after rlast.
- Round-robin: ports 0,1,2 request continuously. Expect grant order 0,1,2,0,1,2 with m_axi_arvalid every 2nd cycle.
- Backpressure: hold m_axi_arready=0 for 10 cycles in ISSUE. Expect:
  - araddr, arid and arlen stable throughout.
  - No s_axi_arready pulses.
- Outstanding limit: port0 issues 4 bursts with no R returned. Expect:
  - 5th request not granted while ports 1/2 are still granted.
  - After one rlast to port0, the 5th is granted.
- R stall: s_axi_rready[2]=0 while an R beat is tagged for port 2. Expect m_axi_rready=0 and the beat held. Ports 0/1 are unaffected on AR.
- Bad tag and reset: inject m_axi_rid tag=3 with PORTS=3. Expect the beat is accepted and err_bad_tag=1. Then assert resetn=0 mid-ISSUE: expect m_axi_arvalid=0 and err_bad_tag=0 immediately (asynchronously).
